// File: rtl/ext_irq_pkg.sv
// ext_irq_pkg: shared state encoding, config field offsets and line mapping for the interrupt gateway
package ext_irq_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, IN_SERVICE} state_t;
  localparam int EN_BIT = 3;
  localparam int EDGE_BIT = 2;
  localparam int PRIO_LSB = 0;
  localparam int IRQ_HI = 1;
  localparam int IRQ_LO = 0;
endpackage

// File: rtl/ext_irq_src.sv
// ext_irq_src: one source's synchroniser, event capture, config register, re-pend flag and service FSM
module ext_irq_src
  import ext_irq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       src_i,
  input  logic       cfg_we_i,
  input  logic [3:0] cfg_wdata_i,
  input  logic       grant_i,
  input  logic       complete_i,
  output logic       pend_o,
  output logic [1:0] prio_o
);
  logic [1:0] sync_q;
  logic       prev_q;
  logic [3:0] cfg_q;
  logic       repend_q, repend_d;
  state_t     state_q, state_d;
  logic       rise, edge_mode, evt, armed, kill, again;
  assign rise = sync_q[1] & ~prev_q;
  assign edge_mode = cfg_q[EDGE_BIT];
  assign evt = edge_mode ? rise : sync_q[1];
  assign armed = cfg_q[EN_BIT] & |cfg_q[PRIO_LSB +: 2];
  // a write that disables the source or zeroes its priority withdraws a pending request
  assign kill = cfg_we_i & ~(cfg_wdata_i[EN_BIT] & |cfg_wdata_i[PRIO_LSB +: 2]);
  // an edge coinciding with completion counts as a re-pend
  assign again = repend_q | (edge_mode & rise);
  assign pend_o = state_q == PENDING;
  assign prio_o = cfg_q[PRIO_LSB +: 2];
  // synchroniser, edge history, config and FSM state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cfg_q <= '0;
      repend_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q <= {sync_q[0], src_i};
      prev_q <= sync_q[1];
      cfg_q <= cfg_we_i ? cfg_wdata_i : cfg_q;
      repend_q <= repend_d;
      state_q <= state_d;
    end
  end
  // service state transitions; an ack outranks a same-cycle config withdrawal
  always_comb begin
    state_d = state_q;
    repend_d = repend_q;
    case (state_q)
      IDLE: state_d = (evt & armed & ~kill) ? PENDING : IDLE;
      PENDING: state_d = grant_i ? IN_SERVICE : kill ? IDLE : PENDING;
      IN_SERVICE: begin
        repend_d = complete_i ? 1'b0 : again;
        state_d = !complete_i ? IN_SERVICE : (again & armed) ? PENDING : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/ext_irq_gateway.sv
// ext_irq_gateway: collects external interrupt sources and delivers them on a two-line req/ack interface
module ext_irq_gateway
  import ext_irq_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               cfg_we,
  input  logic [ID_W-1:0]    cfg_idx,
  input  logic [3:0]         cfg_wdata,
  input  logic               complete_i,
  input  logic [ID_W-1:0]    complete_id_i,
  output logic [1:0]         irq_o,
  input  logic [1:0]         ack_i,
  output logic [ID_W-1:0]    claim_id_o,
  output logic               claim_valid_o
);
  logic [NUM_SRC-1:0]      pend;
  logic [NUM_SRC-1:0][1:0] prio;
  logic                    win_valid_q, win_valid_d;
  logic [ID_W-1:0]         win_id_q, win_id_d;
  logic [1:0]              win_prio_q, win_prio_d;
  logic                    win_pend, accept;
  logic [ID_W-1:0]         claim_id_q;
  logic                    claim_valid_q;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ext_irq_src u_src (
      .clk        (clk),
      .reset      (reset),
      .src_i      (src_i[i]),
      .cfg_we_i   (cfg_we && cfg_idx == ID_W'(i)),
      .cfg_wdata_i(cfg_wdata),
      .grant_i    (accept && win_id_q == ID_W'(i)),
      .complete_i (complete_i && complete_id_i == ID_W'(i)),
      .pend_o     (pend[i]),
      .prio_o     (prio[i])
    );
  end
  assign irq_o[IRQ_HI] = win_valid_q & win_prio_q[1];
  assign irq_o[IRQ_LO] = win_valid_q & ~win_prio_q[1];
  // only the asserted line can be acked, and only while the registered winner is still pending
  assign accept = win_valid_q & win_pend & |(ack_i & irq_o);
  assign claim_id_o = claim_id_q;
  assign claim_valid_o = claim_valid_q;
  // is the registered winner still pending this cycle
  always_comb begin
    win_pend = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (win_id_q == ID_W'(i)) win_pend = pend[i];
  end
  // highest priority wins, strict compare keeps ties on the lowest index
  always_comb begin
    win_prio_d = '0;
    win_id_d = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (pend[i] && prio[i] > win_prio_d) begin
        win_prio_d = prio[i];
        win_id_d = ID_W'(i);
      end
    win_valid_d = |win_prio_d & ~accept;
  end
  // winner register and claim outputs; an accepted ack blanks the request for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      win_valid_q <= 1'b0;
      win_id_q <= '0;
      win_prio_q <= '0;
      claim_id_q <= '0;
      claim_valid_q <= 1'b0;
    end else begin
      win_valid_q <= win_valid_d;
      win_id_q <= win_id_d;
      win_prio_q <= win_prio_d;
      claim_id_q <= accept ? win_id_q : claim_id_q;
      claim_valid_q <= accept;
    end
  end
endmodule

// File: tb/tb_ext_irq_gateway.sv
// tb_ext_irq_gateway: directed self-checking bench for the external interrupt gateway
module tb_ext_irq_gateway;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src_i;
  logic       cfg_we;
  logic [4:0] cfg_idx;
  logic [3:0] cfg_wdata;
  logic       complete_i;
  logic [4:0] complete_id_i;
  logic [1:0] irq_o;
  logic [1:0] ack_i;
  logic [4:0] claim_id_o;
  logic       claim_valid_o;
  int         n_cmp = 0;
  int         n_bad = 0;

  ext_irq_gateway #(.NUM_SRC(8), .ID_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_i        (src_i),
    .cfg_we       (cfg_we),
    .cfg_idx      (cfg_idx),
    .cfg_wdata    (cfg_wdata),
    .complete_i   (complete_i),
    .complete_id_i(complete_id_i),
    .irq_o        (irq_o),
    .ack_i        (ack_i),
    .claim_id_o   (claim_id_o),
    .claim_valid_o(claim_valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfgw(input logic [4:0] idx, input logic [3:0] d);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] m);
    src_i = src_i | m;
    tick(1);
    src_i = src_i & ~m;
  endtask

  task automatic ack(input logic [1:0] a);
    ack_i = a;
    tick(1);
    ack_i = 2'b00;
  endtask

  task automatic complete(input logic [4:0] id);
    complete_i = 1'b1;
    complete_id_i = id;
    tick(1);
    complete_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    src_i = '0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_wdata = '0;
    complete_i = 1'b0;
    complete_id_i = '0;
    ack_i = '0;
    tick(3);
    chk("rst_irq", irq_o, 2'b00);
    chk("rst_cv", claim_valid_o, 1'b0);
    chk("rst_cid", claim_id_o, 5'd0);
    reset = 1'b0;
    // single edge source, high line
    cfgw(3, 4'b1111);
    pulse(8'h08);
    tick(2);
    chk("t1_irq_early", irq_o, 2'b00);
    tick(1);
    chk("t1_irq", irq_o, 2'b10);
    ack(2'b10);
    chk("t1_cv", claim_valid_o, 1'b1);
    chk("t1_cid", claim_id_o, 5'd3);
    chk("t1_irq_forced", irq_o, 2'b00);
    tick(1);
    chk("t1_cv_pulse", claim_valid_o, 1'b0);
    chk("t1_irq_insvc", irq_o, 2'b00);
    complete(3);
    // tie on prio 2 goes to lowest index, then the low line
    cfgw(1, 4'b1110);
    cfgw(5, 4'b1110);
    cfgw(6, 4'b1101);
    pulse(8'h62);
    tick(3);
    chk("t2_irq_a", irq_o, 2'b10);
    ack(2'b10);
    chk("t2_cid1", claim_id_o, 5'd1);
    chk("t2_irq_forced", irq_o, 2'b00);
    tick(1);
    chk("t2_irq_b", irq_o, 2'b10);
    ack(2'b01);
    chk("t2_wrong_line_cv", claim_valid_o, 1'b0);
    chk("t2_wrong_line_irq", irq_o, 2'b10);
    ack(2'b10);
    chk("t2_cv5", claim_valid_o, 1'b1);
    chk("t2_cid5", claim_id_o, 5'd5);
    tick(1);
    chk("t2_irq_lo", irq_o, 2'b01);
    ack(2'b11);
    chk("t2_cv6", claim_valid_o, 1'b1);
    chk("t2_cid6", claim_id_o, 5'd6);
    tick(1);
    chk("t2_idle_irq", irq_o, 2'b00);
    chk("t2_cid_hold", claim_id_o, 5'd6);
    complete(1);
    complete(5);
    complete(6);
    // index beyond NUM_SRC must not alias onto source 0
    cfgw(8, 4'b1111);
    pulse(8'h01);
    tick(4);
    chk("t_oob_irq", irq_o, 2'b00);
    // level source held high re-pends after completion
    cfgw(2, 4'b1011);
    src_i[2] = 1'b1;
    tick(3);
    chk("t3_irq_early", irq_o, 2'b00);
    tick(1);
    chk("t3_irq", irq_o, 2'b10);
    ack(2'b10);
    chk("t3_cid", claim_id_o, 5'd2);
    tick(2);
    chk("t3_insvc_irq", irq_o, 2'b00);
    complete(2);
    chk("t3_c0", irq_o, 2'b00);
    tick(1);
    chk("t3_c1", irq_o, 2'b00);
    tick(1);
    chk("t3_reassert", irq_o, 2'b10);
    ack(2'b10);
    chk("t3_cid2", claim_id_o, 5'd2);
    chk("t3_cv2", claim_valid_o, 1'b1);
    src_i[2] = 1'b0;
    tick(3);
    complete(2);
    tick(4);
    chk("t3_released", irq_o, 2'b00);
    // edge during service re-pends exactly once
    cfgw(4, 4'b1101);
    pulse(8'h10);
    tick(3);
    chk("t4_irq", irq_o, 2'b01);
    ack(2'b01);
    chk("t4_cid", claim_id_o, 5'd4);
    pulse(8'h10);
    tick(4);
    chk("t4_insvc_irq", irq_o, 2'b00);
    complete(4);
    chk("t4_c0", irq_o, 2'b00);
    tick(1);
    chk("t4_reassert", irq_o, 2'b01);
    ack(2'b01);
    chk("t4_cv2", claim_valid_o, 1'b1);
    chk("t4_cid2", claim_id_o, 5'd4);
    complete(4);
    tick(4);
    chk("t4_once_irq", irq_o, 2'b00);
    chk("t4_once_cv", claim_valid_o, 1'b0);
    // disabling a pending source withdraws the request
    cfgw(7, 4'b1101);
    pulse(8'h80);
    tick(3);
    chk("t5_irq", irq_o, 2'b01);
    cfgw(7, 4'b0101);
    tick(1);
    chk("t5_dropped", irq_o, 2'b00);
    ack(2'b01);
    chk("t5_no_claim", claim_valid_o, 1'b0);
    chk("t5_cid_hold", claim_id_o, 5'd4);
    // reset mid-service clears everything including config
    pulse(8'h0A);
    tick(3);
    chk("t6_irq", irq_o, 2'b10);
    ack(2'b10);
    chk("t6_cid", claim_id_o, 5'd3);
    tick(1);
    chk("t6_next", irq_o, 2'b10);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_irq", irq_o, 2'b00);
    chk("t6_rst_cv", claim_valid_o, 1'b0);
    chk("t6_rst_cid", claim_id_o, 5'd0);
    reset = 1'b0;
    pulse(8'h0A);
    tick(5);
    chk("t6_disabled", irq_o, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
